// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and default constants for the 7-bit UART transmitter.
//   state_t        : transmitter FSM states
//   DEF_DATA_W     : default data bits per frame
//   DEF_OVERSAMPLE : default clock cycles per bit period
//   DEF_FRAME_LEN  : default frame length in clock cycles
//   cnt_width()    : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_DATA_W     = 7;
    localparam int DEF_OVERSAMPLE = 2;
    // start + data + parity + stop
    localparam int DEF_FRAME_BITS = DEF_DATA_W + 3;
    localparam int DEF_FRAME_LEN  = DEF_FRAME_BITS * DEF_OVERSAMPLE;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // A counter that only ever needs to hold 0 still needs one bit of storage.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_7b_if.sv
// ---------------------------------------------------------------------------
// uart_tx_7b_if
// Panel-side signal bundle of the UART transmitter.
//   mode     : 1 = single-shot, 0 = continuous
//   en_start : asynchronous start button
//   Din      : character to send
//   TxD      : serial line (idles high)
//   busy     : frame in progress
// Modports: master = user/panel side, slave = transmitter.
// ---------------------------------------------------------------------------
interface uart_tx_7b_if
    import uart_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              mode;
    logic              en_start;
    logic [DATA_W-1:0] Din;
    logic              TxD;
    logic              busy;

    modport master (
        output mode,
        output en_start,
        output Din,
        input  TxD,
        input  busy
    );

    modport slave (
        input  mode,
        input  en_start,
        input  Din,
        output TxD,
        output busy
    );

endinterface

// File: rtl/uart_sync_edge.sv
// ---------------------------------------------------------------------------
// uart_sync_edge
// Brings the asynchronous start button into the clock domain and turns its
// rising edge into a single-cycle pulse.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   async_in    : raw button level
//   start_pulse : one-cycle pulse per rising edge of async_in
// ---------------------------------------------------------------------------
module uart_sync_edge
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic start_pulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    // sync1/sync2 form the metastability synchronizer; sync3 holds the
    // previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A held button produces only one pulse.
    assign start_pulse = sync2 & ~sync3;

endmodule

// File: rtl/uart_tx_7b.sv
// ---------------------------------------------------------------------------
// uart_tx_7b
// UART transmitter: 1 start bit, DATA_W data bits LSB first, one parity bit,
// 1 stop bit. Each bit lasts OVERSAMPLE clock cycles.
//   clk2x : the only clock (OVERSAMPLE x baud)
//   rst_n : asynchronous active-low reset; aborts any frame, TxD goes high
//   bus   : slave side of uart_tx_7b_if (mode, en_start, Din, TxD, busy)
// Parameters: DATA_W, OVERSAMPLE (>= 1), PARITY_ODD (0 = even parity).
// ---------------------------------------------------------------------------
module uart_tx_7b
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic          clk2x,
    input  logic          rst_n,
    uart_tx_7b_if.slave   bus
);

    localparam int TICK_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_W);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                parity_bit;
    logic                txd_q;
    logic                busy_q;

    logic                start_pulse;
    logic                tick_done;
    logic                launch;
    logic [DATA_W-1:0]   shreg_next;
    logic                din_parity;

    uart_sync_edge u_sync_edge (
        .clk         (clk2x),
        .rst_n       (rst_n),
        .async_in    (bus.en_start),
        .start_pulse (start_pulse)
    );

    assign tick_done  = (tick_cnt == TICK_LAST);
    assign shreg_next = shreg >> 1;
    assign din_parity = (^bus.Din) ^ PARITY_ODD;

    // A frame starts either from IDLE (button edge in single-shot mode, or
    // immediately in continuous mode) or straight out of the last STOP cycle
    // in continuous mode, which gives back-to-back frames with no idle gap.
    // Mode is only looked at here, so a switch mid-frame waits for the end.
    always_comb begin
        launch = 1'b0;
        if (state == IDLE) begin
            launch = bus.mode ? start_pulse : 1'b1;
        end else if (state == STOP && tick_done && !bus.mode) begin
            launch = 1'b1;
        end
    end

    // Transmitter FSM. TxD and busy are registered so the line is glitch
    // free; the async reset forces the line high without waiting for a clock.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else if (launch) begin
            // Din is captured once here, so later changes cannot leak in.
            state      <= START;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= bus.Din;
            parity_bit <= din_parity;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                START: begin
                    if (tick_done) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        txd_q    <= shreg[0];
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_done) begin
                        tick_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= PARITY;
                            txd_q <= parity_bit;
                        end else begin
                            // Pre-shift so the next bit is on the line
                            // at the start of its own bit period.
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg_next;
                            txd_q   <= shreg_next[0];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_done) begin
                        state    <= STOP;
                        tick_cnt <= '0;
                        txd_q    <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Continuous relaunch is handled by the launch branch.
                    if (tick_done) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        txd_q    <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    txd_q    <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TxD  = txd_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_uart_tx_7b.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_7b
// Self-checking bench for uart_tx_7b: table of single-shot frames, a
// continuous-mode run with random characters against a frame model, a
// retrigger-while-busy sequence, a mode switch and an async reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_7b;
    import uart_pkg::*;

    localparam int OS = DEF_OVERSAMPLE;
    localparam int DW = DEF_DATA_W;

    logic clk2x = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_tx_7b_if #(.DATA_W(DW)) bus ();

    uart_tx_7b #(
        .DATA_W     (DW),
        .OVERSAMPLE (OS),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk2x (clk2x),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk2x = ~clk2x;

    // seq holds the 10 line bits in transmit order, first bit at [9].
    typedef struct {
        logic [6:0] din;
        logic [9:0] seq;
        int         hold;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_txd"}, bus.TxD, 1'b1);
        checkOutput({name, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic applyStimulus(input logic m, input logic e, input logic [6:0] d);
        bus.mode     = m;
        bus.en_start = e;
        bus.Din      = d;
    endtask

    // Line bit number idx of a frame carrying d: start, data LSB first,
    // even parity, stop.
    function automatic logic frame_bit(input logic [6:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 7) return d[idx-1];
        if (idx == 8) return ^d;
        return 1'b1;
    endfunction

    initial begin
        logic [9:0] cont_seq;
        logic [6:0] cur;
        logic [6:0] nxt;
        logic [6:0] r;
        int         p;

        // Reset held with a pressed button in continuous mode: line stays idle.
        applyStimulus(1'b0, 1'b1, 7'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk2x);
            checkIdle("reset_hold");
        end
        applyStimulus(1'b1, 1'b0, 7'h00);
        @(negedge clk2x);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2x);
            checkIdle("post_reset");
        end

        vecs[0] = '{din: 7'b1010101, seq: 10'b0101010101, hold: 40};
        vecs[1] = '{din: 7'b0000000, seq: 10'b0000000001, hold: 2};
        vecs[2] = '{din: 7'b1111111, seq: 10'b0111111111, hold: 2};
        vecs[3] = '{din: 7'b0000001, seq: 10'b0100000011, hold: 2};
        vecs[4] = '{din: 7'b1100100, seq: 10'b0001001111, hold: 2};

        // Single-shot frames: button pressed at c=0, two cycles of sync
        // latency, 20 frame cycles, then the button is held and must not
        // retrigger. Din is flipped mid-frame and must not matter.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, vecs[i].din);
            for (int c = 1; c <= 22 + vecs[i].hold; c++) begin
                @(negedge clk2x);
                if (c <= 2) begin
                    checkIdle("ss_latency");
                end else if (c <= 22) begin
                    p = c - 3;
                    checkOutput($sformatf("ss_v%0d_c%0d_txd", i, p), bus.TxD, vecs[i].seq[9 - p/OS]);
                    checkOutput($sformatf("ss_v%0d_c%0d_busy", i, p), bus.busy, 1'b1);
                end else begin
                    checkIdle($sformatf("ss_v%0d_after", i));
                end
                if (c == 8) bus.Din = ~vecs[i].din;
            end
            bus.en_start = 1'b0;
            for (int g = 0; g < 4; g++) begin
                @(negedge clk2x);
                checkIdle("ss_gap");
            end
        end

        // Continuous mode: three fixed frames, then random characters with
        // Din noise mid-frame; a switch to single-shot mid-way through the
        // last frame lets it finish and then the line must stay idle.
        cont_seq = 10'b0010101011;
        cur      = 7'b0101010;
        applyStimulus(1'b0, 1'b0, cur);
        for (int f = 0; f < 13; f++) begin
            for (int q = 0; q < 20; q++) begin
                @(negedge clk2x);
                if (f < 3)
                    checkOutput($sformatf("cont_f%0d_c%0d_txd", f, q), bus.TxD, cont_seq[9 - q/OS]);
                else
                    checkOutput($sformatf("rand_f%0d_c%0d_txd", f, q), bus.TxD, frame_bit(cur, q/OS));
                checkOutput($sformatf("cont_f%0d_c%0d_busy", f, q), bus.busy, 1'b1);
                if (f == 12 && q == 7) bus.mode = 1'b1;
                if (q == 19) begin
                    nxt     = (f < 2) ? 7'b0101010 : 7'($urandom);
                    bus.Din = nxt;
                    cur     = nxt;
                end else if (f >= 3) begin
                    bus.Din = 7'($urandom);
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk2x);
            checkIdle("mode_switch_idle");
        end

        // Second button press while the frame is running is dropped.
        r = 7'($urandom);
        applyStimulus(1'b1, 1'b1, r);
        for (int c = 1; c <= 62; c++) begin
            @(negedge clk2x);
            if (c <= 2) begin
                checkIdle("retrig_latency");
            end else if (c <= 22) begin
                p = c - 3;
                checkOutput($sformatf("retrig_c%0d_txd", p), bus.TxD, frame_bit(r, p/OS));
                checkOutput($sformatf("retrig_c%0d_busy", p), bus.busy, 1'b1);
            end else begin
                checkIdle("retrig_idle");
            end
            if (c == 4)  bus.en_start = 1'b0;
            if (c == 11) bus.en_start = 1'b1;
            if (c == 13) bus.en_start = 1'b0;
        end

        // Async reset during the start bit: line must return high with no
        // clock edge, stay idle while held, and restart cleanly afterwards.
        applyStimulus(1'b0, 1'b1, 7'($urandom));
        @(negedge clk2x);
        checkOutput("pre_rst_start_txd", bus.TxD, 1'b0);
        checkOutput("pre_rst_start_busy", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_txd", bus.TxD, 1'b1);
        checkOutput("async_rst_busy", bus.busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2x);
            checkIdle("rst_hold_mid");
        end
        rst_n = 1'b1;
        @(negedge clk2x);
        checkOutput("relaunch_after_rst_txd", bus.TxD, 1'b0);
        checkOutput("relaunch_after_rst_busy", bus.busy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
